// File: rtl/arith_pipe_pkg.sv
// Shared width helpers and signed range constants for the (a + b) * d - c pipeline.
// Optional feature macro used by the top level: ARITH_PIPE_SAT_EN (saturating width reduction).
package arith_pipe_pkg;

    // Width of a + b for W-bit unsigned operands.
    function automatic int sum_w(input int w);
        return w + 1;
    endfunction

    // Width of (a + b) * d.
    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

    // Width of the exact signed result (a + b) * d - c.
    function automatic int full_w(input int w);
        return 2 * w + 2;
    endfunction

    // Largest signed value representable in rw bits (rw <= 64).
    function automatic longint res_max(input int rw);
        return (longint'(1) << (rw - 1)) - 1;
    endfunction

    // Smallest signed value representable in rw bits (rw <= 64).
    function automatic longint res_min(input int rw);
        return -(longint'(1) << (rw - 1));
    endfunction

endpackage

// File: rtl/arith_pipe_stage.sv
// One pipeline register slice: valid bit plus data word, advanced when en is high.
module arith_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic          valid_reg;
    logic [DW-1:0] data_reg;

    // Capture valid and data together whenever the pipeline is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (en) begin
            valid_reg <= in_valid;
            data_reg  <= in_data;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;

endmodule

// File: rtl/arith_pipe_sub_mul.sv
// Three-stage pipeline computing res = (a + b) * d - c with valid/ready handshakes.
// Define ARITH_PIPE_SAT_EN to saturate res on overflow; otherwise res wraps.
// Saturation constants come from 64-bit helpers, so RES_W is limited to 64.
module arith_pipe_sub_mul
    import arith_pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int RES_W = 2 * W + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] res,
    output logic             ovf,
    output logic [1:0]       inflight
);

    localparam int SUM_W  = sum_w(W);
    localparam int PROD_W = prod_w(W);
    localparam int FULL_W = full_w(W);
    localparam int S1_W   = SUM_W + 2 * W;
    localparam int S2_W   = PROD_W + W;
    localparam int S3_W   = RES_W + 1;

    logic stall;
    logic en;

    // Whole pipeline freezes while the consumer refuses a valid result.
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // ---------------- S1: sum, with c and d carried along ----------------
    logic [S1_W-1:0]  s1_in;
    logic [S1_W-1:0]  s1_data;
    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic [W-1:0]     s1_c;
    logic [W-1:0]     s1_d;

    assign s1_in = {SUM_W'(a) + SUM_W'(b), c, d};

    arith_pipe_stage #(.DW(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_data  (s1_data)
    );

    assign {s1_sum, s1_c, s1_d} = s1_data;

    // ---------------- S2: product, with c carried along ----------------
    logic [S2_W-1:0]   s2_in;
    logic [S2_W-1:0]   s2_data;
    logic              s2_valid;
    logic [PROD_W-1:0] s2_prod;
    logic [W-1:0]      s2_c;

    assign s2_in = {PROD_W'(s1_sum) * PROD_W'(s1_d), s1_c};

    arith_pipe_stage #(.DW(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (s1_valid),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_data  (s2_data)
    );

    assign {s2_prod, s2_c} = s2_data;

    // ---------------- S3: subtract and reduce to RES_W ----------------
    // Both operands are non-negative, so a plain FULL_W-bit subtract yields the
    // correct two's complement result.
    logic [FULL_W-1:0] full;
    logic [RES_W-1:0]  red_res;
    logic              red_ovf;

    assign full = {1'b0, s2_prod} - FULL_W'(s2_c);

    generate
        if (RES_W >= FULL_W) begin : g_extend
            assign red_res = RES_W'($signed(full));
            assign red_ovf = 1'b0;
        end else begin : g_reduce
            // Fits only if every bit from the RES_W sign bit upward equals the top bit.
            logic fits;
            assign fits    = (full[FULL_W-1:RES_W-1] == {(FULL_W-RES_W+1){full[FULL_W-1]}});
            assign red_ovf = ~fits;
`ifdef ARITH_PIPE_SAT_EN
            localparam logic [RES_W-1:0] RES_MAX = RES_W'(res_max(RES_W));
            localparam logic [RES_W-1:0] RES_MIN = RES_W'(res_min(RES_W));
            assign red_res = fits ? full[RES_W-1:0]
                                  : (full[FULL_W-1] ? RES_MIN : RES_MAX);
`else
            assign red_res = full[RES_W-1:0];
`endif
        end
    endgenerate

    logic [S3_W-1:0] s3_data;

    arith_pipe_stage #(.DW(S3_W)) u_s3 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (s2_valid),
        .in_data   ({red_ovf, red_res}),
        .out_valid (out_valid),
        .out_data  (s3_data)
    );

    assign {ovf, res} = s3_data;

    assign inflight = {1'b0, s1_valid} + {1'b0, s2_valid} + {1'b0, out_valid};

endmodule

// File: tb/tb_arith_pipe_sub_mul.sv
// Scoreboard bench for arith_pipe_sub_mul: a full-width instance (W=8) and a
// narrow instance (W=2, RES_W=4) share the handshake controls.
// Honours ARITH_PIPE_SAT_EN in its reference model.
module tb_arith_pipe_sub_mul;

    typedef struct {
        logic [63:0] res;
        bit          ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a_op, b_op, c_op, d_op;
    logic [1:0]  a2_op, b2_op, c2_op, d2_op;

    logic        in_ready, out_valid, ovf;
    logic [17:0] res;
    logic [1:0]  inflight;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [3:0]  res_b;
    logic [1:0]  inflight_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    arith_pipe_sub_mul #(.W(8), .RES_W(18)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_op), .b(b_op), .c(c_op), .d(d_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .ovf(ovf), .inflight(inflight)
    );

    arith_pipe_sub_mul #(.W(2), .RES_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .a(a2_op), .b(b2_op), .c(c2_op), .d(d2_op),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .res(res_b), .ovf(ovf_b), .inflight(inflight_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Exact integer result, then range check and wrap/saturate into rw bits.
    function automatic exp_t model(input longint a, input longint b, input longint c,
                                   input longint d, input int rw);
        longint full;
        longint mx;
        longint mn;
        longint r;
        exp_t   e;
        full  = (a + b) * d - c;
        mx    = (longint'(1) << (rw - 1)) - 1;
        mn    = -mx - 1;
        e.ovf = (full > mx) || (full < mn);
        r     = full;
`ifdef ARITH_PIPE_SAT_EN
        if (full > mx) r = mx;
        else if (full < mn) r = mn;
`endif
        e.res = 64'(r) & ((64'd1 << rw) - 1);
        return e;
    endfunction

    task automatic set_ops(input int a, input int b, input int c, input int d,
                           input int a2, input int b2, input int c2, input int d2);
        a_op = 8'(a); b_op = 8'(b); c_op = 8'(c); d_op = 8'(d);
        a2_op = 2'(a2); b2_op = 2'(b2); c2_op = 2'(c2); d2_op = 2'(d2);
    endtask

    // Random operands, biased towards the extremes that exercise the range checks.
    task automatic rand_ops();
        case ($urandom_range(0, 5))
            0: set_ops(255, 255, 0, 255, 3, 3, 0, 3);
            1: set_ops(0, 0, 255, 0, 0, 0, 3, 0);
            default: set_ops($urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 3));
        endcase
    endtask

    // One cycle of stimulus; the expected result is queued once the op is accepted.
    task automatic drive(input bit v, input bit ordy, output bit rdy_s, output logic [1:0] inf_s);
        bit acc_a;
        bit acc_b;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        rdy_s = in_ready;
        inf_s = inflight;
        acc_a = in_valid && in_ready && !rst;
        acc_b = in_valid && in_ready_b && !rst;
        @(posedge clk);
        #1;
        if (acc_a) qa.push_back(model(a_op, b_op, c_op, d_op, 18));
        if (acc_b) qb.push_back(model(a2_op, b2_op, c2_op, d2_op, 4));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // Monitor: pops and compares on every output transfer, checks hold-during-stall.
    initial begin
        exp_t        e;
        bit          stall_prev = 1'b0;
        logic [17:0] held_res = '0;
        logic        held_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                chk("inflight", 64'(inflight), 64'(qa.size()));
                chk("inflight_b", 64'(inflight_b), 64'(qb.size()));
                if (stall_prev) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_res", 64'(res), 64'(held_res));
                    chk("hold_ovf", 64'(ovf), 64'(held_ovf));
                end
                if (out_valid && out_ready) begin
                    if (qa.size() == 0) begin
                        chk("spurious_out", 64'(qa.size()), 64'd1);
                    end else begin
                        e = qa.pop_front();
                        chk("res", 64'(res), e.res);
                        chk("ovf", 64'(ovf), 64'(e.ovf));
                    end
                end
                if (out_valid_b && out_ready) begin
                    if (qb.size() == 0) begin
                        chk("spurious_out_b", 64'(qb.size()), 64'd1);
                    end else begin
                        e = qb.pop_front();
                        chk("res_b", 64'(res_b), e.res);
                        chk("ovf_b", 64'(ovf_b), 64'(e.ovf));
                    end
                end
                stall_prev = out_valid && !out_ready;
                held_res   = res;
                held_ovf   = ovf;
            end
        end
    end

    initial begin
        bit         rdy;
        logic [1:0] inf;
        int         n;
        bit         found;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_res", 64'(res), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_inflight", 64'(inflight), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed boundary ops followed by random ops, 10 back to back.
        set_ops(3, 3, 0, 3, 3, 3, 0, 3);        drive(1, 1, rdy, inf);
        set_ops(0, 0, 3, 0, 0, 0, 3, 0);        drive(1, 1, rdy, inf);
        set_ops(255, 255, 0, 255, 3, 3, 0, 3);  drive(1, 1, rdy, inf);
        set_ops(0, 0, 255, 0, 0, 0, 3, 0);      drive(1, 1, rdy, inf);
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            drive(1, 1, rdy, inf);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, rdy, inf);
        chk("stream_drained", 64'(qa.size()), 64'd0);

        // Backpressure: fill, stall 4 cycles, release.
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            drive(1, 1, rdy, inf);
        end
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            drive(1, 0, rdy, inf);
            chk("stall_in_ready", 64'(rdy), 64'd0);
            chk("stall_inflight", 64'(inf), 64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            drive(1, 1, rdy, inf);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, rdy, inf);
        chk("release_drained", 64'(qa.size()), 64'd0);

        // Reset with two ops in flight.
        for (int i = 0; i < 2; i++) begin
            rand_ops();
            drive(1, 1, rdy, inf);
        end
        do_reset();
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_inflight", 64'(inflight), 64'd0);
        chk("midreset_res", 64'(res), 64'd0);
        @(posedge clk);
        #1;

        // Latency of the first op after reset, and a single-cycle result pulse.
        set_ops(10, 20, 5, 7, 1, 2, 3, 2);
        drive(1, 1, rdy, inf);
        in_valid = 1'b0;
        n = 0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            n++;
            if (out_valid) found = 1'b1;
        end
        chk("latency", 64'(n), 64'd3);
        @(negedge clk);
        chk("single_pulse", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, rdy, inf);
        end
        for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++) drive(0, 1, rdy, inf);
        chk("final_drained", 64'(qa.size()), 64'd0);
        chk("final_drained_b", 64'(qb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
